// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: FSM state encodings shared by the memory port arbiter and its users
package mem_port_arbiter_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;
  function automatic logic is_busy(input logic [1:0] s);
    return (s == ST_FETCH) || (s == ST_DATA);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// mem_port_arbiter_watchdog: counts cycles of an outstanding memory request and flags expiry
module mem_port_arbiter_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  assign expire_o = en_i & (cnt_q == CW'(TIMEOUT_CYC - 1));
  // cycle counter, restarted whenever no request is outstanding
  always_ff @(posedge clock_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between instruction fetch and data access
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_LIM  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_done_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              bus_err_o,
  output logic              if_stall_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i
);
  localparam int SW = $clog2(STARVE_LIM + 1);
  logic [1:0]        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic              if_done_q, if_done_d, dm_done_q, dm_done_d, bus_err_q, bus_err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, req_addr;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d, rsp_data;
  logic              busy, expire, fetch_el, data_el, gnt_data, gnt_fetch, finish;

  assign busy      = is_busy(state_q);
  assign fetch_el  = if_req_i & ~if_done_q;
  assign data_el   = dm_req_i & ~dm_done_q;
  assign gnt_data  = (state_q == ST_IDLE) & data_el & ~(fetch_el & (starve_q == SW'(STARVE_LIM)));
  assign gnt_fetch = (state_q == ST_IDLE) & ~gnt_data & fetch_el;
  assign req_addr  = gnt_data ? dm_addr_i : if_addr_i;
  assign finish    = busy & (mem_ready_i | expire);
  assign rsp_data  = mem_ready_i ? mem_rdata_i : '0;

  mem_port_arbiter_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .clr_i    (~busy),
    .en_i     (busy),
    .expire_o (expire)
  );

  // next state: arbitration in IDLE, completion or timeout in FETCH/DATA, one RESP cycle
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    bus_err_d   = 1'b0;
    starve_d    = (~if_req_i | gnt_fetch) ? '0 :
                  (gnt_data & (starve_q != SW'(STARVE_LIM))) ? starve_q + 1'b1 : starve_q;
    if (gnt_data & (dm_addr_i[1:0] != 2'b00)) begin
      state_d    = ST_RESP;
      dm_done_d  = 1'b1;
      bus_err_d  = 1'b1;
      dm_rdata_d = '0;
    end else if (gnt_data | gnt_fetch) begin
      state_d     = gnt_data ? ST_DATA : ST_FETCH;
      mem_req_d   = 1'b1;
      mem_we_d    = gnt_data & dm_we_i;
      mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
      mem_wdata_d = gnt_data ? dm_wdata_i : '0;
    end else if (finish) begin
      state_d    = ST_RESP;
      mem_req_d  = 1'b0;
      mem_we_d   = 1'b0;
      bus_err_d  = ~mem_ready_i;
      if_done_d  = state_q == ST_FETCH;
      dm_done_d  = state_q == ST_DATA;
      if_rdata_d = (state_q == ST_FETCH) ? rsp_data : if_rdata_q;
      dm_rdata_d = (state_q == ST_DATA) ? rsp_data : dm_rdata_q;
    end else if (state_q == ST_RESP) begin
      state_d = ST_IDLE;
    end
  end

  // state and registered outputs; reset abandons any transaction without a done pulse
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign if_done_o   = if_done_q;
  assign dm_done_o   = dm_done_q;
  assign bus_err_o   = bus_err_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_stall_o  = if_req_i & ~if_done_q;
  assign dm_stall_o  = dm_req_i & ~dm_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors and corner-case sequences for the memory port arbiter
module tb_mem_port_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic        if_done, dm_done, bus_err, if_stall, dm_stall, mem_req, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  int          lat = 0;
  bit          hang = 1'b0;
  int          wcnt = 0;
  int          errors = 0, checks = 0;

  typedef struct {
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          hang;
    int          exp_edges;
    int          exp_req;
    bit          exp_err;
    bit          chk_rd;
    logic [31:0] exp_rdata;
  } vec_t;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4), .TIMEOUT_CYC(8)) dut (
    .clock_i(clock), .reset_i(reset),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_done_o(if_done), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_done_o(dm_done), .dm_rdata_o(dm_rdata), .bus_err_o(bus_err),
    .if_stall_o(if_stall), .dm_stall_o(dm_stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a == 32'h28) ? 32'h8D4E0004 : {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // memory model: ready after lat wait cycles of a held request, never when hung
  always @(negedge clock) begin
    if (mem_req && !hang && wcnt == lat) begin
      mem_ready = 1'b1;
      mem_rdata = pat(mem_addr);
      wcnt = 0;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 32'hBAD0BAD0;
      wcnt = mem_req ? wcnt + 1 : 0;
    end
  end

  always @(negedge clock)
    if (!reset) chk("both_done", 32'(if_done & dm_done), 32'd0);

  task automatic run_vec(input int n, input vec_t v);
    int e, rq;
    bit seen, other;
    lat = v.lat;
    hang = v.hang;
    if (v.fetch) begin
      if_addr = v.addr;
      if_req = 1'b1;
    end else begin
      dm_we = v.we;
      dm_addr = v.addr;
      dm_wdata = v.wdata;
      dm_req = 1'b1;
    end
    e = 0; rq = 0; seen = 0; other = 0;
    while (!seen && e < 50) begin
      @(posedge clock); #1;
      e++;
      if (mem_req) begin
        if (rq == 0) begin
          chk($sformatf("v%0d_mem_addr", n), mem_addr, v.addr & ~32'h3);
          chk($sformatf("v%0d_mem_we", n), 32'(mem_we), 32'(v.we & ~v.fetch));
          if (v.we) chk($sformatf("v%0d_mem_wdata", n), mem_wdata, v.wdata);
        end
        rq++;
      end
      seen = v.fetch ? if_done : dm_done;
      if (v.fetch ? dm_done : if_done) other = 1'b1;
    end
    chk($sformatf("v%0d_done_edges", n), 32'(e), 32'(v.exp_edges));
    chk($sformatf("v%0d_req_cycles", n), 32'(rq), 32'(v.exp_req));
    chk($sformatf("v%0d_bus_err", n), 32'(bus_err), 32'(v.exp_err));
    chk($sformatf("v%0d_other_done", n), 32'(other), 32'd0);
    chk($sformatf("v%0d_stall", n), 32'(v.fetch ? if_stall : dm_stall), 32'd0);
    if (v.chk_rd) chk($sformatf("v%0d_rdata", n), v.fetch ? if_rdata : dm_rdata, v.exp_rdata);
    if_req = 1'b0;
    dm_req = 1'b0;
    @(posedge clock); #1;
    chk($sformatf("v%0d_idle_quiet", n), {29'd0, bus_err, if_done, dm_done}, 32'd0);
  endtask

  initial begin
    vec_t vt[10];
    int e, ed, ef, nd, k;
    logic [6:0] ord;
    vt[0] = '{1'b1, 1'b0, 32'h28, 32'h0,        0, 1'b0, 2, 1, 1'b0, 1'b1, pat(32'h28)};
    vt[1] = '{1'b0, 1'b0, 32'h0C, 32'h0,        0, 1'b0, 2, 1, 1'b0, 1'b1, pat(32'h0C)};
    vt[2] = '{1'b0, 1'b0, 32'h40, 32'h0,        3, 1'b0, 5, 4, 1'b0, 1'b1, pat(32'h40)};
    vt[3] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1, 1'b0, 3, 2, 1'b0, 1'b0, 32'h0};
    vt[4] = '{1'b0, 1'b1, 32'h12, 32'h12345678, 0, 1'b0, 1, 0, 1'b1, 1'b1, 32'h0};
    vt[5] = '{1'b0, 1'b0, 32'h0D, 32'h0,        0, 1'b0, 1, 0, 1'b1, 1'b1, 32'h0};
    vt[6] = '{1'b0, 1'b0, 32'h20, 32'h0,        0, 1'b1, 9, 8, 1'b1, 1'b1, 32'h0};
    vt[7] = '{1'b1, 1'b0, 32'h2C, 32'h0,        2, 1'b0, 4, 3, 1'b0, 1'b1, pat(32'h2C)};
    vt[8] = '{1'b0, 1'b0, 32'h30, 32'h0,        7, 1'b0, 9, 8, 1'b0, 1'b1, pat(32'h30)};
    vt[9] = '{1'b1, 1'b0, 32'h34, 32'h0,        0, 1'b1, 9, 8, 1'b1, 1'b1, 32'h0};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_outputs", {28'd0, mem_req, if_done, dm_done, bus_err}, 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata | mem_addr, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vt[i]);

    hang = 1'b1;
    if_addr = 32'h44;
    if_req = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("midrst_mem_req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    ed = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      if (c == 0) chk("midrst_mem_req_after", 32'(mem_req), 32'd0);
      if (if_done || dm_done) ed++;
    end
    chk("midrst_no_done", 32'(ed), 32'd0);
    chk("midrst_outputs", {29'd0, mem_req, mem_we, bus_err}, 32'd0);
    chk("midrst_regs", if_rdata | dm_rdata | mem_addr | mem_wdata, 32'd0);
    reset = 1'b0;
    if_req = 1'b0;
    hang = 1'b0;
    @(posedge clock); #1;

    lat = 0;
    dm_we = 1'b0;
    dm_addr = 32'h0C;
    if_addr = 32'h30;
    if_req = 1'b1;
    dm_req = 1'b1;
    e = 0; ed = 0; ef = 0;
    while ((ed == 0 || ef == 0) && e < 40) begin
      @(posedge clock); #1;
      e++;
      if (dm_done && ed == 0) begin
        ed = e;
        dm_req = 1'b0;
        chk("coll_dm_rdata", dm_rdata, pat(32'h0C));
      end
      if (if_done && ef == 0) begin
        ef = e;
        if_req = 1'b0;
        chk("coll_if_rdata", if_rdata, pat(32'h30));
      end
    end
    chk("coll_dm_edge", 32'(ed), 32'd2);
    chk("coll_if_edge", 32'(ef), 32'd5);
    @(posedge clock); #1;

    if_addr = 32'h40;
    dm_addr = 32'h100;
    if_req = 1'b1;
    dm_req = 1'b1;
    e = 0; nd = 0; k = 0; ord = '0;
    while (k < 7 && e < 200) begin
      @(posedge clock); #1;
      e++;
      if (dm_done) begin
        ord = {ord[5:0], 1'b1};
        k++; nd++;
        dm_addr = dm_addr + 32'h4;
        if (nd == 6) dm_req = 1'b0;
      end
      if (if_done) begin
        ord = {ord[5:0], 1'b0};
        k++;
        if_req = 1'b0;
      end
    end
    chk("starve_count", 32'(k), 32'd7);
    chk("starve_order", 32'(ord), 32'b1111011);
    @(posedge clock); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
